// File: rtl/fmc516_spi3w_wb_if.sv
// Wishbone pipelined-mode bus bundle between the FMC516 crossbar and the
// three-wire SPI configuration controller.
interface fmc516_spi3w_wb_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        stall;

    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, stall);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, stall);
endinterface

// File: rtl/fmc516_spi3w_wb.sv
// Wishbone slave driving the FMC516 ADCs' shared three-wire SPI config bus.
// Optional feature: define FMC516_SPI_LSB_EN to make CTRL[11] (LSB-first) writable.
module fmc516_spi3w_wb #(
    parameter int unsigned g_default_div = 3
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    fmc516_spi3w_wb_if.slave wb,
    output logic             sys_spi_clk_o,
    inout  wire              sys_spi_data_b,
    output logic             sys_spi_cs_adc0_n_o,
    output logic             sys_spi_cs_adc1_n_o,
    output logic             sys_spi_cs_adc2_n_o,
    output logic             sys_spi_cs_adc3_n_o
);
    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t      state_q, state_d;
    logic        ack_q;
    logic [31:0] dat_q, rd_d;
    logic [31:0] rxtx_q, rx_q, rx_d;
    logic [5:0]  char_len_q;
    logic        rx_neg_q, tx_neg_q, lsb_q, ass_q, dir_q;
    logic [15:0] div_q, cnt_q;
    logic [3:0]  ss_q;
    logic        sclk_q;
    logic [6:0]  edge_q, edge_last;
    logic [4:0]  tx_cnt_q, bit_idx, rx_top;
    logic [5:0]  n_len;
    logic [2:0]  idx;
    logic        req, wr, start, busy;
    logic        toggle, last_edge, rx_smp, tx_adv, tx_bit, pin_in, oe;
    logic        unused_adr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

    assign idx        = wb.adr[4:2];
    assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};
    assign req        = wb.cyc & wb.stb;
    assign busy       = (state_q == S_XFER);
    assign wr         = req & wb.we & ~busy;
    assign start      = wr && (idx == 3'd4) && wb.sel[1] && wb.dat_w[8];

    // CHAR_LEN of 0 (or anything past 32) runs a full 32-bit word
    assign n_len     = (char_len_q == 6'd0 || char_len_q > 6'd32) ? 6'd32 : char_len_q;
    assign edge_last = {n_len, 1'b0} - 7'd1;
    assign bit_idx   = lsb_q ? tx_cnt_q : 5'(n_len - 6'd1 - {1'b0, tx_cnt_q});
    assign rx_top    = 5'(n_len - 6'd1);
    assign tx_bit    = rxtx_q[bit_idx];
    assign oe        = busy & dir_q;
    assign pin_in    = dir_q ? tx_bit : sys_spi_data_b;

    assign sys_spi_data_b      = oe ? tx_bit : 1'bz;
    assign sys_spi_clk_o       = sclk_q;
    assign sys_spi_cs_adc0_n_o = ~(ss_q[0] & (~ass_q | busy));
    assign sys_spi_cs_adc1_n_o = ~(ss_q[1] & (~ass_q | busy));
    assign sys_spi_cs_adc2_n_o = ~(ss_q[2] & (~ass_q | busy));
    assign sys_spi_cs_adc3_n_o = ~(ss_q[3] & (~ass_q | busy));

    assign wb.ack   = ack_q;
    assign wb.dat_r = dat_q;
    assign wb.stall = 1'b0;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        toggle    = 1'b0;
        last_edge = 1'b0;
        rx_smp    = 1'b0;
        tx_adv    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_XFER;
            S_XFER: begin
                toggle    = (cnt_q == 16'd0);
                last_edge = toggle && (edge_q == edge_last);
                rx_smp    = toggle && (sclk_q == rx_neg_q);
                // the first bit is already on the pin, so rising-edge TX skips edge 0
                tx_adv    = toggle && !last_edge &&
                            (tx_neg_q ? sclk_q : (!sclk_q && edge_q != 7'd0));
                if (last_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_d = rx_q;
        if (rx_smp) begin
            if (lsb_q) begin
                rx_d         = rx_q >> 1;
                rx_d[rx_top] = pin_in;
            end else begin
                rx_d = {rx_q[30:0], pin_in};
            end
        end
    end

    always_comb begin
        rd_d = 32'd0;
        case (idx)
            3'd0:    rd_d = rxtx_q;
            3'd4:    rd_d = {17'd0, dir_q, ass_q, 1'b0, lsb_q, tx_neg_q, rx_neg_q,
                             busy, 2'b00, char_len_q};
            3'd5:    rd_d = {16'd0, div_q};
            3'd6:    rd_d = {28'd0, ss_q};
            default: rd_d = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            rxtx_q     <= 32'd0;
            rx_q       <= 32'd0;
            char_len_q <= 6'd0;
            rx_neg_q   <= 1'b0;
            tx_neg_q   <= 1'b0;
            lsb_q      <= 1'b0;
            ass_q      <= 1'b0;
            dir_q      <= 1'b0;
            div_q      <= 16'(g_default_div);
            ss_q       <= 4'd0;
            cnt_q      <= 16'd0;
            sclk_q     <= 1'b0;
            edge_q     <= 7'd0;
            tx_cnt_q   <= 5'd0;
        end else begin
            ack_q <= req;
            if (req && !wb.we) dat_q <= rd_d;
            if (wr) begin
                case (idx)
                    3'd0: rxtx_q <= merge_bytes(rxtx_q, wb.dat_w, wb.sel);
                    3'd4: begin
                        if (wb.sel[0]) char_len_q <= wb.dat_w[5:0];
                        if (wb.sel[1]) begin
                            rx_neg_q <= wb.dat_w[9];
                            tx_neg_q <= wb.dat_w[10];
                            ass_q    <= wb.dat_w[13];
                            dir_q    <= wb.dat_w[14];
`ifdef FMC516_SPI_LSB_EN
                            lsb_q    <= wb.dat_w[11];
`else
                            lsb_q    <= 1'b0;
`endif
                        end
                    end
                    3'd5: div_q <= {wb.sel[1] ? wb.dat_w[15:8] : div_q[15:8],
                                    wb.sel[0] ? wb.dat_w[7:0]  : div_q[7:0]};
                    3'd6: if (wb.sel[0]) ss_q <= wb.dat_w[3:0];
                    default: ;
                endcase
            end
            if (start) begin
                cnt_q    <= div_q;
                sclk_q   <= 1'b0;
                edge_q   <= 7'd0;
                tx_cnt_q <= 5'd0;
                rx_q     <= 32'd0;
            end else if (busy) begin
                rx_q <= rx_d;
                if (toggle) begin
                    cnt_q  <= div_q;
                    sclk_q <= ~sclk_q;
                    edge_q <= edge_q + 7'd1;
                end else begin
                    cnt_q <= cnt_q - 16'd1;
                end
                if (tx_adv)    tx_cnt_q <= tx_cnt_q + 5'd1;
                if (last_edge) rxtx_q   <= rx_d;
            end
        end
    end
endmodule

// File: tb/tb_fmc516_spi3w_wb.sv
// Directed bench for fmc516_spi3w_wb: register access, write/read transfers,
// busy write protection, static chip selects and mid-transfer reset.
`timescale 1ns/1ps
module tb_fmc516_spi3w_wb;
    logic clk = 1'b0;
    logic rst;
    logic sclk, cs0_n, cs1_n, cs2_n, cs3_n;
    wire  spi_data;
    wire  [3:0] cs_n = {cs3_n, cs2_n, cs1_n, cs0_n};
    logic tb_oe, tb_val, model_en;
    int   n_chk = 0, n_err = 0;
    int   rise_cnt, cs_bad, drv_bad;
    logic [31:0] pin_log, r;
    time  t_acc, t_go, t_rise;

    fmc516_spi3w_wb_if wb();

    fmc516_spi3w_wb #(.g_default_div(3)) dut (
        .sys_clk_i           (clk),
        .sys_rst_i           (rst),
        .wb                  (wb),
        .sys_spi_clk_o       (sclk),
        .sys_spi_data_b      (spi_data),
        .sys_spi_cs_adc0_n_o (cs0_n),
        .sys_spi_cs_adc1_n_o (cs1_n),
        .sys_spi_cs_adc2_n_o (cs2_n),
        .sys_spi_cs_adc3_n_o (cs3_n)
    );

    assign spi_data = tb_oe ? tb_val : 1'bz;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    always @(posedge sclk) begin
        if (rise_cnt == 0) t_rise = $time;
        rise_cnt = rise_cnt + 1;
        pin_log  = {pin_log[30:0], spi_data};
        if (cs0_n) cs_bad = cs_bad + 1;
        if (tb_oe && spi_data !== tb_val) drv_bad = drv_bad + 1;
    end

    // ADC model for read transfers: drive 1 once selected, toggle after each falling sclk
    always @(negedge cs0_n) if (model_en) begin tb_val = 1'b1; tb_oe = 1'b1; end
    always @(negedge sclk)  if (model_en && tb_oe) tb_val = ~tb_val;
    always @(posedge cs0_n) if (model_en) tb_oe = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [2:0] widx, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        @(negedge clk);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
        wb.adr = {27'd0, widx, 2'b00}; wb.dat_w = wdat; wb.sel = sel;
        @(posedge clk);
        t_acc = $time;
        #1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        check("ack", {31'd0, wb.ack}, 32'd1);
        rdat = wb.dat_r;
    endtask

    task automatic wr(input logic [2:0] widx, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, widx, wdat, 4'hF, dummy);
    endtask

    task automatic rd(input logic [2:0] widx, output logic [31:0] rdat);
        wb_xfer(1'b0, widx, 32'd0, 4'h0, rdat);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] c;
        int n = 0;
        do begin
            rd(3'd4, c);
            n++;
        end while (c[8] && n < 1000);
        check({tag, "_done"}, {31'd0, c[8]}, 32'd0);
    endtask

    task automatic check_pin_free(input string tag);
        tb_oe = 1'b1; tb_val = 1'b0; #1;
        check({tag, "_lo"}, {31'd0, spi_data}, 32'd0);
        tb_val = 1'b1; #1;
        check({tag, "_hi"}, {31'd0, spi_data}, 32'd1);
        tb_oe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tb_oe = 1'b0; tb_val = 1'b0; model_en = 1'b0;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.adr = 32'd0; wb.dat_w = 32'd0; wb.sel = 4'h0;
        rise_cnt = 0; cs_bad = 0; drv_bad = 0; pin_log = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_cs",   {28'd0, cs_n}, 32'h0000_000F);
        check("rst_ack",  {31'd0, wb.ack}, 32'd0);
        check("rst_dat",  wb.dat_r, 32'd0);
        check_pin_free("rst_pin");
        @(negedge clk) rst = 1'b0;

        rd(3'd0, r); check("rst_rxtx", r, 32'd0);
        rd(3'd4, r); check("rst_ctrl", r, 32'd0);
        rd(3'd5, r); check("rst_div",  r, 32'd3);
        rd(3'd6, r); check("rst_ss",   r, 32'd0);
        rd(3'd7, r); check("rd_unmapped", r, 32'd0);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, wb.ack}, 32'd0);

        // 32-bit write transfer
        wr(3'd0, 32'hAAAA_AAAA);
        wr(3'd4, 32'h0000_6420);
        wr(3'd6, 32'h1);
        rise_cnt = 0; cs_bad = 0;
        wr(3'd4, 32'h0000_6520);
        check("w32_cs_start", {28'd0, cs_n}, 32'h0000_000E);
        check("w32_first_bit", {31'd0, spi_data}, 32'd1);
        rd(3'd4, r); check("w32_busy", r, 32'h0000_6520);
        wait_idle("w32");
        check("w32_rises", rise_cnt, 32);
        check("w32_bits", pin_log, 32'hAAAA_AAAA);
        check("w32_cs_only_during", cs_bad, 0);
        check("w32_cs_end", {28'd0, cs_n}, 32'h0000_000F);
        check("w32_sclk_end", {31'd0, sclk}, 32'd0);
        check_pin_free("w32_pin_end");

        // 32-bit read transfer
        wr(3'd0, 32'h1234_5678);
        wr(3'd4, 32'h0000_2420);
        model_en = 1'b1; drv_bad = 0; rise_cnt = 0;
        wr(3'd4, 32'h0000_2520);
        wait_idle("r32");
        model_en = 1'b0;
        check("r32_rises", rise_cnt, 32);
        check("r32_no_dut_drive", drv_bad, 0);
        rd(3'd0, r); check("r32_rxtx", r, 32'hAAAA_AAAA);

        // 8-bit write transfer; writes while busy must be ignored
        wr(3'd0, 32'h0000_00A5);
        wr(3'd4, 32'h0000_6408);
        rise_cnt = 0; cs_bad = 0;
        wr(3'd4, 32'h0000_6508);
        t_go = t_acc;
        wr(3'd0, 32'h0000_005A);
        wr(3'd6, 32'h0000_000F);
        wr(3'd5, 32'h0000_0009);
        wait_idle("w8");
        check("w8_rises", rise_cnt, 8);
        check("w8_bits", pin_log & 32'hFF, 32'h0000_00A5);
        check("w8_first_rise", 32'((t_rise - t_go) / 10), 32'd4);
        check("w8_cs_end", {28'd0, cs_n}, 32'h0000_000F);
        rd(3'd6, r); check("busy_ss_ignored", r, 32'd1);
        rd(3'd5, r); check("busy_div_ignored", r, 32'd3);

        // static chip selects with ASS = 0
        wr(3'd6, 32'h0000_000A);
        wr(3'd4, 32'h0000_0000);
        check("ass0_cs", {28'd0, cs_n}, 32'h0000_0005);

        // reset in the middle of a transfer
        wr(3'd6, 32'h1);
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd4, 32'h0000_6420);
        rise_cnt = 0;
        wr(3'd4, 32'h0000_6520);
        repeat (60) @(posedge clk);
        #1;
        check("mid_active_cs", {28'd0, cs_n}, 32'h0000_000E);
        check("mid_active_sclk", {31'd0, sclk}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_cs", {28'd0, cs_n}, 32'h0000_000F);
        check_pin_free("mid_rst_pin");
        @(negedge clk) rst = 1'b0;
        rd(3'd4, r); check("mid_rst_ctrl", r, 32'd0);
        rd(3'd0, r); check("mid_rst_rxtx", r, 32'd0);
        rd(3'd6, r); check("mid_rst_ss", r, 32'd0);
        rd(3'd5, r); check("mid_rst_div", r, 32'd3);

        // next transfer after reset, with DIVIDER = 1
        wr(3'd5, 32'h1);
        wr(3'd6, 32'h1);
        wr(3'd0, 32'h0000_003C);
        wr(3'd4, 32'h0000_6408);
        rise_cnt = 0;
        wr(3'd4, 32'h0000_6508);
        t_go = t_acc;
        wait_idle("post");
        check("post_rises", rise_cnt, 8);
        check("post_bits", pin_log & 32'hFF, 32'h0000_003C);
        check("post_first_rise", 32'((t_rise - t_go) / 10), 32'd2);
        check("post_cs_end", {28'd0, cs_n}, 32'h0000_000F);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
